// File: rtl/hsi_adjust_pipe.sv
// hsi_adjust_pipe: per-pixel hue rotation and saturation/intensity contrast
// adjustment around mid-scale. Channel levels are captured at start of frame.
// Latency: 3 cycles, one pixel per clock sustained.
// Backpressure: none; iVALID=0 cycles travel down the pipe as bubbles.
//
// Optional feature macro: HSI_RAMP_EN
//   defined   - applied levels step one unit per SOF toward the captured target,
//               and oRAMP_BUSY reports any channel still ramping.
//   undefined - applied levels jump to the captured target at the SOF,
//               and oRAMP_BUSY is tied low.
//
// Ports:
//   iCLK, iRST_N               clock, asynchronous active-low reset
//   iVALID, iSOF               pixel valid, start of frame (qualified by iVALID)
//   iH, iS, iI                 input hue / saturation / intensity
//   iH_EN, iS_EN, iI_EN        per-channel adjustment enables
//   iH_LVL, iS_LVL, iI_LVL     requested levels, 4-bit two's complement
//   oVALID, oSOF               delayed valid / SOF, aligned with output pixel
//   oH, oS, oI                 adjusted pixel, held while oVALID=0
//   oRAMP_BUSY                 some applied level has not reached its target
module hsi_adjust_pipe #(
   parameter int H_W    = 9,
   parameter int SI_W   = 8,
   parameter int H_MAX  = 360,
   parameter int H_STEP = 5
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   input  logic            iVALID,
   input  logic            iSOF,
   input  logic [H_W-1:0]  iH,
   input  logic [SI_W-1:0] iS,
   input  logic [SI_W-1:0] iI,
   input  logic            iH_EN,
   input  logic            iS_EN,
   input  logic            iI_EN,
   input  logic [3:0]      iH_LVL,
   input  logic [3:0]      iS_LVL,
   input  logic [3:0]      iI_LVL,
   output logic            oVALID,
   output logic            oSOF,
   output logic [H_W-1:0]  oH,
   output logic [SI_W-1:0] oS,
   output logic [SI_W-1:0] oI,
   output logic            oRAMP_BUSY
);

   // Hue sum range is roughly -7*H_STEP .. H_MAX-1+7*H_STEP, so two extra bits
   // (sign + headroom) suffice. Sat/int product (x-MID)*lvl is at most
   // 2^(SI_W-1)*7 in magnitude, covered by SI_W+5 signed bits.
   localparam int HS_W = H_W + 2;
   localparam int PW   = SI_W + 5;

   localparam logic [H_W:0]             H_MAX_U  = (H_W+1)'(H_MAX);
   localparam logic [H_W-1:0]           H_LAST   = H_W'(H_MAX - 1);
   localparam logic signed [HS_W-1:0]   H_MAX_S  = HS_W'(H_MAX);
   localparam logic signed [HS_W-1:0]   H_STEP_S = HS_W'(H_STEP);
   localparam logic signed [PW-1:0]     MID_S    = PW'(2 ** (SI_W - 1));
   localparam logic signed [PW-1:0]     SI_MAX_S = PW'(2 ** SI_W - 1);

   // ---------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------

   // Disabled channel targets zero; -8 is folded to -7 so the level range is
   // symmetric.
   function automatic logic signed [3:0] lvl_target(input logic en,
                                                    input logic [3:0] lvl);
      logic signed [3:0] t;
      if (!en)
         t = 4'sd0;
      else if (lvl == 4'b1000)
         t = -4'sd7;
      else
         t = $signed(lvl);
      return t;
   endfunction

`ifdef HSI_RAMP_EN
   // One unit toward the target, passing through zero like any integer.
   function automatic logic signed [3:0] lvl_step(input logic signed [3:0] cur,
                                                  input logic signed [3:0] tgt);
      logic signed [3:0] n;
      if (tgt > cur)
         n = cur + 4'sd1;
      else if (tgt < cur)
         n = cur - 4'sd1;
      else
         n = cur;
      return n;
   endfunction
`endif

   // floor(((x - MID) * lvl) / 8): arithmetic shift floors toward -inf.
   function automatic logic signed [PW-1:0] si_delta(input logic [SI_W-1:0] x,
                                                     input logic signed [3:0] lvl);
      logic signed [PW-1:0] dev;
      logic signed [PW-1:0] prod;
      dev  = $signed({5'b00000, x}) - MID_S;
      prod = dev * $signed({{(PW-4){lvl[3]}}, lvl});
      return prod >>> 3;
   endfunction

   // Level offset never exceeds one hue period, so a single correction in
   // either direction brings the sum back into 0..H_MAX-1.
   function automatic logic [H_W-1:0] hue_wrap(input logic signed [HS_W-1:0] v);
      logic [H_W-1:0] r;
      if (v[HS_W-1])
         r = H_W'(v + H_MAX_S);
      else if (v >= H_MAX_S)
         r = H_W'(v - H_MAX_S);
      else
         r = H_W'(v);
      return r;
   endfunction

   function automatic logic [SI_W-1:0] si_clamp(input logic [SI_W-1:0] x,
                                                input logic signed [PW-1:0] delta);
      logic signed [PW-1:0] sum;
      logic [SI_W-1:0]      r;
      sum = $signed({5'b00000, x}) + delta;
      if (sum[PW-1])
         r = '0;
      else if (sum > SI_MAX_S)
         r = '1;
      else
         r = sum[SI_W-1:0];
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Level control: capture at SOF, applied level used from the SOF pixel on
   // ---------------------------------------------------------------------
   logic              capture;
   logic signed [3:0] tgt_h_d, tgt_s_d, tgt_i_d;
   logic signed [3:0] appl_h_q, appl_s_q, appl_i_q;
   logic signed [3:0] appl_h_d, appl_s_d, appl_i_d;

   assign capture = iVALID & iSOF;

   always_comb begin
      tgt_h_d = lvl_target(iH_EN, iH_LVL);
      tgt_s_d = lvl_target(iS_EN, iS_LVL);
      tgt_i_d = lvl_target(iI_EN, iI_LVL);
   end

`ifdef HSI_RAMP_EN
   logic signed [3:0] tgt_h_q, tgt_s_q, tgt_i_q;

   always_comb begin
      appl_h_d = appl_h_q;
      appl_s_d = appl_s_q;
      appl_i_d = appl_i_q;
      if (capture) begin
         appl_h_d = lvl_step(appl_h_q, tgt_h_d);
         appl_s_d = lvl_step(appl_s_q, tgt_s_d);
         appl_i_d = lvl_step(appl_i_q, tgt_i_d);
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         tgt_h_q <= '0;
         tgt_s_q <= '0;
         tgt_i_q <= '0;
      end else if (capture) begin
         tgt_h_q <= tgt_h_d;
         tgt_s_q <= tgt_s_d;
         tgt_i_q <= tgt_i_d;
      end
   end

   assign oRAMP_BUSY = (appl_h_q != tgt_h_q) || (appl_s_q != tgt_s_q) ||
                       (appl_i_q != tgt_i_q);
`else
   always_comb begin
      appl_h_d = appl_h_q;
      appl_s_d = appl_s_q;
      appl_i_d = appl_i_q;
      if (capture) begin
         appl_h_d = tgt_h_d;
         appl_s_d = tgt_s_d;
         appl_i_d = tgt_i_d;
      end
   end

   assign oRAMP_BUSY = 1'b0;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         appl_h_q <= '0;
         appl_s_q <= '0;
         appl_i_q <= '0;
      end else begin
         appl_h_q <= appl_h_d;
         appl_s_q <= appl_s_d;
         appl_i_q <= appl_i_d;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 1: hue range clamp, bind the pixel to its applied levels
   // ---------------------------------------------------------------------
   logic              s1_vld_q, s1_sof_q;
   logic [H_W-1:0]    s1_h_q, s1_h_d;
   logic [SI_W-1:0]   s1_s_q, s1_i_q;
   logic signed [3:0] s1_lh_q, s1_ls_q, s1_li_q;

   assign s1_h_d = ({1'b0, iH} >= H_MAX_U) ? H_LAST : iH;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         s1_vld_q <= 1'b0;
         s1_sof_q <= 1'b0;
         s1_h_q   <= '0;
         s1_s_q   <= '0;
         s1_i_q   <= '0;
         s1_lh_q  <= '0;
         s1_ls_q  <= '0;
         s1_li_q  <= '0;
      end else begin
         s1_vld_q <= iVALID;
         s1_sof_q <= capture;
         if (iVALID) begin
            s1_h_q  <= s1_h_d;
            s1_s_q  <= iS;
            s1_i_q  <= iI;
            s1_lh_q <= appl_h_d;
            s1_ls_q <= appl_s_d;
            s1_li_q <= appl_i_d;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: raw hue sum, scaled sat/int deviation
   // ---------------------------------------------------------------------
   logic                   s2_vld_q, s2_sof_q;
   logic signed [HS_W-1:0] s2_hsum_q, s2_hsum_d;
   logic [SI_W-1:0]        s2_s_q, s2_i_q;
   logic signed [PW-1:0]   s2_sdel_q, s2_sdel_d;
   logic signed [PW-1:0]   s2_idel_q, s2_idel_d;

   always_comb begin
      s2_hsum_d = $signed({2'b00, s1_h_q}) +
                  $signed({{(HS_W-4){s1_lh_q[3]}}, s1_lh_q}) * H_STEP_S;
      s2_sdel_d = si_delta(s1_s_q, s1_ls_q);
      s2_idel_d = si_delta(s1_i_q, s1_li_q);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         s2_vld_q  <= 1'b0;
         s2_sof_q  <= 1'b0;
         s2_hsum_q <= '0;
         s2_s_q    <= '0;
         s2_i_q    <= '0;
         s2_sdel_q <= '0;
         s2_idel_q <= '0;
      end else begin
         s2_vld_q <= s1_vld_q;
         s2_sof_q <= s1_sof_q;
         if (s1_vld_q) begin
            s2_hsum_q <= s2_hsum_d;
            s2_s_q    <= s1_s_q;
            s2_i_q    <= s1_i_q;
            s2_sdel_q <= s2_sdel_d;
            s2_idel_q <= s2_idel_d;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 3: hue wrap, sat/int clamp; output data holds across bubbles
   // ---------------------------------------------------------------------
   logic            ovld_q, osof_q;
   logic [H_W-1:0]  oh_q, oh_d;
   logic [SI_W-1:0] os_q, os_d, oi_q, oi_d;

   always_comb begin
      oh_d = hue_wrap(s2_hsum_q);
      os_d = si_clamp(s2_s_q, s2_sdel_q);
      oi_d = si_clamp(s2_i_q, s2_idel_q);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         ovld_q <= 1'b0;
         osof_q <= 1'b0;
         oh_q   <= '0;
         os_q   <= '0;
         oi_q   <= '0;
      end else begin
         ovld_q <= s2_vld_q;
         osof_q <= s2_sof_q;
         if (s2_vld_q) begin
            oh_q <= oh_d;
            os_q <= os_d;
            oi_q <= oi_d;
         end
      end
   end

   assign oVALID = ovld_q;
   assign oSOF   = osof_q;
   assign oH     = oh_q;
   assign oS     = os_q;
   assign oI     = oi_q;

endmodule

// File: tb/tb_hsi_adjust_pipe.sv
// tb_hsi_adjust_pipe: directed table of SOF pixels with hand-computed results,
// plus sequences for mid-frame control changes, level ramping, bubble
// propagation and reset in the middle of a frame.
module tb_hsi_adjust_pipe;
   localparam int H_W  = 9;
   localparam int SI_W = 8;
`ifdef HSI_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif
   // Enough SOFs to walk an applied level from -7 to +7 when ramping.
   localparam int NSOF = RAMP ? 15 : 1;

   logic            iCLK = 1'b0;
   logic            iRST_N = 1'b0;
   logic            iVALID = 1'b0, iSOF = 1'b0;
   logic [H_W-1:0]  iH = '0;
   logic [SI_W-1:0] iS = '0, iI = '0;
   logic            iH_EN = 1'b0, iS_EN = 1'b0, iI_EN = 1'b0;
   logic [3:0]      iH_LVL = '0, iS_LVL = '0, iI_LVL = '0;
   logic            oVALID, oSOF, oRAMP_BUSY;
   logic [H_W-1:0]  oH;
   logic [SI_W-1:0] oS, oI;

   hsi_adjust_pipe dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iVALID(iVALID), .iSOF(iSOF),
      .iH(iH), .iS(iS), .iI(iI),
      .iH_EN(iH_EN), .iS_EN(iS_EN), .iI_EN(iI_EN),
      .iH_LVL(iH_LVL), .iS_LVL(iS_LVL), .iI_LVL(iI_LVL),
      .oVALID(oVALID), .oSOF(oSOF), .oH(oH), .oS(oS), .oI(oI),
      .oRAMP_BUSY(oRAMP_BUSY)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [8:0] h;
      logic [7:0] s, i;
      logic       hen, sen, ien;
      logic [3:0] hl, sl, il;
      int         eh, es, ei;
   } vec_t;

   vec_t vecs[8];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic sof, input logic [8:0] h,
                        input logic [7:0] s, input logic [7:0] i,
                        input logic hen, input logic sen, input logic ien,
                        input logic [3:0] hl, input logic [3:0] sl, input logic [3:0] il);
      iVALID = v;   iSOF = sof;
      iH = h;       iS = s;       iI = i;
      iH_EN = hen;  iS_EN = sen;  iI_EN = ien;
      iH_LVL = hl;  iS_LVL = sl;  iI_LVL = il;
   endtask

   task automatic idle();
      iVALID = 1'b0;
      iSOF   = 1'b0;
   endtask

   // Called at a negedge: sends NSOF back-to-back SOF pixels, then idles so the
   // caller is left at the negedge where the last pixel is at the output.
   task automatic sof_burst(input logic [8:0] h, input logic [7:0] s, input logic [7:0] i,
                            input logic hen, input logic sen, input logic ien,
                            input logic [3:0] hl, input logic [3:0] sl, input logic [3:0] il);
      for (int j = 0; j < NSOF; j++) begin
         drive(1'b1, 1'b1, h, s, i, hen, sen, ien, hl, sl, il);
         @(negedge iCLK);
      end
      idle();
      repeat (2) @(negedge iCLK);
   endtask

   initial begin
      int  hexp;
      bit  vpat[16];

      //            h    s    i    hen  sen  ien  hl     sl     il     eh   es   ei
      vecs[0] = '{9'd355, 8'd100, 8'd128, 1'b1, 1'b0, 1'b1, 4'd2,  4'd0,  4'd5,  5,   100, 128};
      vecs[1] = '{9'd3,   8'd255, 8'd50,  1'b1, 1'b1, 1'b1, 4'hF,  4'd7,  4'd0,  358, 255, 50};
      vecs[2] = '{9'd400, 8'd0,   8'd128, 1'b1, 1'b1, 1'b1, 4'd0,  4'd7,  4'hD,  359, 0,   128};
      vecs[3] = '{9'd100, 8'd200, 8'd200, 1'b1, 1'b1, 1'b1, 4'd0,  4'hC,  4'd4,  100, 164, 236};
      vecs[4] = '{9'd0,   8'd200, 8'd10,  1'b1, 1'b1, 1'b1, 4'h8,  4'h8,  4'h8,  325, 137, 113};
      vecs[5] = '{9'd359, 8'd77,  8'd3,   1'b0, 1'b0, 1'b0, 4'd7,  4'd7,  4'h8,  359, 77,  3};
      vecs[6] = '{9'd359, 8'd129, 8'd127, 1'b1, 1'b1, 1'b1, 4'd7,  4'd1,  4'd1,  34,  129, 126};
      vecs[7] = '{9'd0,   8'd64,  8'd130, 1'b1, 1'b1, 1'b1, 4'd7,  4'hF,  4'h9,  35,  72,  128};

      // Reset state
      repeat (2) @(negedge iCLK);
      chk("rst_ovalid", 32'(oVALID), 0);
      chk("rst_osof",   32'(oSOF), 0);
      chk("rst_oh",     32'(oH), 0);
      chk("rst_os",     32'(oS), 0);
      chk("rst_oi",     32'(oI), 0);
      chk("rst_busy",   32'(oRAMP_BUSY), 0);
      iRST_N = 1'b1;
      @(negedge iCLK);

      // Table of SOF pixels
      for (int k = 0; k < 8; k++) begin
         sof_burst(vecs[k].h, vecs[k].s, vecs[k].i, vecs[k].hen, vecs[k].sen, vecs[k].ien,
                   vecs[k].hl, vecs[k].sl, vecs[k].il);
         chk($sformatf("vec%0d_vld", k),  32'(oVALID), 1);
         chk($sformatf("vec%0d_sof", k),  32'(oSOF), 1);
         chk($sformatf("vec%0d_h", k),    32'(oH), vecs[k].eh);
         chk($sformatf("vec%0d_s", k),    32'(oS), vecs[k].es);
         chk($sformatf("vec%0d_i", k),    32'(oI), vecs[k].ei);
         chk($sformatf("vec%0d_busy", k), 32'(oRAMP_BUSY), 0);
      end
      // Outputs hold through a bubble
      @(negedge iCLK);
      chk("hold_vld", 32'(oVALID), 0);
      chk("hold_h",   32'(oH), 35);
      chk("hold_s",   32'(oS), 72);

      // Controls changed between SOFs are ignored, as is an unqualified iSOF
      sof_burst(9'd10, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
      chk("mid_pre_h", 32'(oH), 20);
      drive(1'b0, 1'b1, 9'd10, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'hB, 4'd0, 4'd0);
      @(negedge iCLK);
      drive(1'b1, 1'b0, 9'd10, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'hB, 4'd0, 4'd0);
      @(negedge iCLK);
      idle();
      repeat (2) @(negedge iCLK);
      chk("mid_vld", 32'(oVALID), 1);
      chk("mid_sof", 32'(oSOF), 0);
      chk("mid_h",   32'(oH), 20);

      // Ramp from 0 to +3 over three SOFs
      sof_burst(9'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      chk("ramp0_busy", 32'(oRAMP_BUSY), 0);
      for (int it = 0; it < 3; it++) begin
         drive(1'b1, 1'b1, 9'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0);
         @(negedge iCLK);
         idle();
         chk($sformatf("ramp%0d_busy", it + 1), 32'(oRAMP_BUSY),
             (RAMP && it < 2) ? 1 : 0);
         repeat (2) @(negedge iCLK);
         chk($sformatf("ramp%0d_h", it + 1), 32'(oH), RAMP ? 5 * (it + 1) : 15);
      end

      // Alternating valid stream, then reset mid-frame
      sof_burst(9'd100, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
      for (int k = 0; k < 12; k++) begin
         vpat[k] = (k % 2 == 0);
         if (k >= 3) begin
            chk($sformatf("alt%0d_vld", k), 32'(oVALID), 32'(vpat[k-3]));
            if (vpat[k-3]) chk($sformatf("alt%0d_h", k), 32'(oH), 110 + k - 3);
         end
         drive(vpat[k], 1'b0, 9'(100 + k), 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
         @(negedge iCLK);
      end
      drive(1'b1, 1'b0, 9'd200, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
      @(negedge iCLK);
      drive(1'b1, 1'b0, 9'd210, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
      iRST_N = 1'b0;
      #1;
      chk("mrst_vld", 32'(oVALID), 0);
      chk("mrst_h",   32'(oH), 0);
      chk("mrst_sof", 32'(oSOF), 0);
      @(negedge iCLK);
      drive(1'b1, 1'b1, 9'd220, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
      chk("mrst_vld2", 32'(oVALID), 0);
      @(negedge iCLK);
      idle();
      iRST_N = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge iCLK);
         chk($sformatf("post_rst%0d_vld", k), 32'(oVALID), 0);
      end
      // First pixel after release, no SOF: level 0 despite hl=+2 on the inputs
      drive(1'b1, 1'b0, 9'd50, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
      @(negedge iCLK);
      idle();
      repeat (2) @(negedge iCLK);
      chk("post_rst_vld", 32'(oVALID), 1);
      chk("post_rst_h",   32'(oH), 50);
      // Next SOF applies the level again
      drive(1'b1, 1'b1, 9'd50, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
      @(negedge iCLK);
      idle();
      repeat (2) @(negedge iCLK);
      hexp = RAMP ? 55 : 60;
      chk("post_rst_sof_h", 32'(oH), hexp);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
